std_fp_div_arbiter: RTL and testbench

//  Shares one multi-cycle fixed-point divider (std_fp_div_pipe go/done protocol) among NREQ requesters.

---
 rtl/std_fp_div_arbiter_if.sv | 42 ++++
 rtl/std_fp_div_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_std_fp_div_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/std_fp_div_arbiter_if.sv
// Requester, response and divider-side signals of the shared fixed-point divider arbiter.
// master = arbiter side, slave = requesters/consumer/divider side.
interface std_fp_div_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] left_in;
  logic [NREQ*WIDTH-1:0] right_in;
  logic [NREQ-1:0]       ack;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_quotient;
  logic [WIDTH-1:0]      resp_remainder;
  logic                  resp_err;

  logic                  div_go;
  logic [WIDTH-1:0]      div_left;
  logic [WIDTH-1:0]      div_right;
  logic [WIDTH-1:0]      div_quotient;
  logic [WIDTH-1:0]      div_remainder;
  logic                  div_done;

  logic                  busy;

  modport master (
    input  req, left_in, right_in, resp_ready,
    input  div_quotient, div_remainder, div_done,
    output ack, resp_valid, resp_id, resp_quotient, resp_remainder, resp_err,
    output div_go, div_left, div_right, busy
  );

  modport slave (
    output req, left_in, right_in, resp_ready,
    output div_quotient, div_remainder, div_done,
    input  ack, resp_valid, resp_id, resp_quotient, resp_remainder, resp_err,
    input  div_go, div_left, div_right, busy
  );
endinterface

// File: rtl/std_fp_div_arbiter.sv
// Round-robin arbiter sharing one go/done fixed-point divider among NREQ requesters.
// Optional macro STD_FP_DIV_ARB_DIVZERO_EN: zero divisors bypass the divider and report resp_err.
module std_fp_div_arbiter #(
  parameter int WIDTH      = 32,
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 16,
  parameter int NREQ       = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  std_fp_div_arbiter_if.master   bus
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDW-1:0] LAST_INIT = IDW'(NREQ - 1);

  // The Q format only matters to the divider; catch inconsistent instantiations early.
  if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_fmt_check
    $error("std_fp_div_arbiter: INT_WIDTH + FRAC_WIDTH must equal WIDTH");
  end
  if (NREQ < 1) begin : g_nreq_check
    $error("std_fp_div_arbiter: NREQ must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [IDW-1:0]    last, last_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              go_q, go_d;
  logic [WIDTH-1:0]  left_q, left_d;
  logic [WIDTH-1:0]  right_q, right_d;
  logic [IDW-1:0]    id_q, id_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  quot_q, quot_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
`ifdef STD_FP_DIV_ARB_DIVZERO_EN
  logic              err_q, err_d;
`endif

  logic              found;
  logic [IDW-1:0]    winner;
  logic [WIDTH-1:0]  win_left;
  logic [WIDTH-1:0]  win_right;

  // Round-robin search starting just after the last winner, wrapping mod NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && bus.req[(int'(last) + k) % NREQ]) begin
        found  = 1'b1;
        winner = IDW'((int'(last) + k) % NREQ);
      end
    end
  end

  assign win_left  = bus.left_in[int'(winner)*WIDTH +: WIDTH];
  assign win_right = bus.right_in[int'(winner)*WIDTH +: WIDTH];

  always_comb begin
    state_d = state;
    last_d  = last;
    ack_d   = '0;
    go_d    = go_q;
    left_d  = left_q;
    right_d = right_q;
    id_d    = id_q;
    valid_d = valid_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef STD_FP_DIV_ARB_DIVZERO_EN
    err_d   = err_q;
`endif

    unique case (state)
      S_IDLE: begin
        if (found) begin
          ack_d[winner] = 1'b1;
          left_d        = win_left;
          right_d       = win_right;
          id_d          = winner;
          last_d        = winner;
`ifdef STD_FP_DIV_ARB_DIVZERO_EN
          if (win_right == '0) begin
            quot_d  = '1;
            rem_d   = win_left;
            err_d   = 1'b1;
            valid_d = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            go_d    = 1'b1;
            state_d = S_RUN;
          end
`else
          go_d    = 1'b1;
          state_d = S_RUN;
`endif
        end
      end

      S_RUN: begin
        if (bus.div_done) begin
          quot_d  = bus.div_quotient;
          rem_d   = bus.div_remainder;
          valid_d = 1'b1;
          go_d    = 1'b0;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        if (valid_q && bus.resp_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        go_d    = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Every register clears on reset, aborting any in-flight operation without a response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      last    <= LAST_INIT;
      ack_q   <= '0;
      go_q    <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef STD_FP_DIV_ARB_DIVZERO_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      last    <= last_d;
      ack_q   <= ack_d;
      go_q    <= go_d;
      left_q  <= left_d;
      right_q <= right_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef STD_FP_DIV_ARB_DIVZERO_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.ack            = ack_q;
  assign bus.div_go         = go_q;
  assign bus.div_left       = left_q;
  assign bus.div_right      = right_q;
  assign bus.resp_id        = id_q;
  assign bus.resp_valid     = valid_q;
  assign bus.resp_quotient  = quot_q;
  assign bus.resp_remainder = rem_q;
`ifdef STD_FP_DIV_ARB_DIVZERO_EN
  assign bus.resp_err       = err_q;
`else
  assign bus.resp_err       = 1'b0;
`endif
  assign bus.busy           = (state != S_IDLE);

  a_ack_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(ack_q));
  a_go_run:     assert property (@(posedge clk) disable iff (!reset_n) go_q == (state == S_RUN));
  a_valid_resp: assert property (@(posedge clk) disable iff (!reset_n) valid_q == (state == S_RESP));
  a_resp_hold:  assert property (@(posedge clk) disable iff (!reset_n)
                  (valid_q && !bus.resp_ready) |=> (valid_q && $stable(quot_q) && $stable(rem_q) && $stable(id_q)));

endmodule

// File: tb/tb_std_fp_div_arbiter.sv
// Scoreboard bench for std_fp_div_arbiter (NREQ=4, Q16.16) with a behavioural go/done divider.
module tb_std_fp_div_arbiter;
  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int LAT   = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  std_fp_div_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  std_fp_div_arbiter #(
    .WIDTH(WIDTH), .INT_WIDTH(16), .FRAC_WIDTH(16), .NREQ(NREQ)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.master)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Behavioural divider: Q16.16 quotient, LAT cycles after go, waits for go to drop before rearming.
  logic             m_done, m_busy, m_wait, inj_done;
  logic [WIDTH-1:0] m_q, m_r;
  logic [63:0]      m_res;
  int               m_cnt;

  function automatic logic [63:0] fx_div(input logic [31:0] l, input logic [31:0] r);
    logic [63:0] num;
    num = {16'h0, l, 16'h0};
    if (r == 32'd0) return {32'hFFFF_FFFF, l};
    return {32'(num / {32'h0, r}), 32'(num % {32'h0, r})};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_done <= 1'b0; m_busy <= 1'b0; m_wait <= 1'b0;
      m_cnt <= 0; m_q <= '0; m_r <= '0; m_res <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_wait) begin
        if (!bus.div_go) m_wait <= 1'b0;
      end else if (m_busy) begin
        if (m_cnt == 0) begin
          m_done <= 1'b1; m_busy <= 1'b0; m_wait <= 1'b1;
          m_q <= m_res[63:32]; m_r <= m_res[31:0];
        end else m_cnt <= m_cnt - 1;
      end else if (bus.div_go) begin
        m_busy <= 1'b1; m_cnt <= LAT;
        m_res <= fx_div(bus.div_left, bus.div_right);
      end
    end
  end

  assign bus.div_done      = m_done | inj_done;
  assign bus.div_quotient  = inj_done ? 32'hDEAD_BEEF : m_q;
  assign bus.div_remainder = inj_done ? 32'h0BAD_0BAD : m_r;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    q;
    logic [31:0]    r;
    logic           err;
  } resp_t;

  resp_t sb_q[$];
  int    ack_q[$];
  resp_t mon_exp;
  int    mon_e;
  logic [NREQ-1:0] mon_ea;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.ack != '0) begin
        if (ack_q.size() == 0) check("ack_unexpected", 64'(bus.ack), 64'd0);
        else begin
          mon_e = ack_q.pop_front();
          mon_ea = '0;
          mon_ea[mon_e] = 1'b1;
          check("ack_order", 64'(bus.ack), 64'(mon_ea));
        end
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (sb_q.size() == 0) check("resp_unexpected", 64'(bus.resp_id), 64'hFFFF);
        else begin
          mon_exp = sb_q.pop_front();
          check("resp_id", 64'(bus.resp_id), 64'(mon_exp.id));
          check("resp_quotient", 64'(bus.resp_quotient), 64'(mon_exp.q));
          check("resp_remainder", 64'(bus.resp_remainder), 64'(mon_exp.r));
          check("resp_err", 64'(bus.resp_err), 64'(mon_exp.err));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] l, input logic [31:0] r);
    bus.left_in[i*WIDTH +: WIDTH]  = l;
    bus.right_in[i*WIDTH +: WIDTH] = r;
  endtask

  task automatic expect_txn(input int id, input logic [31:0] q, input logic [31:0] r, input logic err);
    resp_t t;
    t.id = IDW'(id); t.q = q; t.r = r; t.err = err;
    ack_q.push_back(id);
    sb_q.push_back(t);
  endtask

  // Waits for n acks, dropping each acknowledged request as a real requester would.
  task automatic serve_acks(input int n);
    for (int k = 0; k < n; k++) begin
      bit got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
        step(1);
        if (bus.ack != '0) begin
          bus.req = bus.req & ~bus.ack;
          got = 1'b1;
        end
      end
      if (!got) check("ack_timeout", 64'd0, 64'd1);
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      step(1);
      if (sb_q.size() == 0 && !bus.busy) done = 1'b1;
    end
    if (!done) check("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_valid();
    bit done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      step(1);
      if (bus.resp_valid) done = 1'b1;
    end
    if (!done) check("valid_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit go_seen;
    bus.req = '0; bus.left_in = '0; bus.right_in = '0;
    bus.resp_ready = 1'b1; inj_done = 1'b0;
    step(3);

    // Reset state
    check("rst_ack", 64'(bus.ack), 64'd0);
    check("rst_div_go", 64'(bus.div_go), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_resp_q", 64'(bus.resp_quotient), 64'd0);
    check("rst_div_left", 64'(bus.div_left), 64'd0);
    reset_n = 1'b1;
    step(1);

    // All four requesting from reset: rr order 0,1,2,3
    set_op(0, 32'h0008_0000, 32'h0004_0000); expect_txn(0, 32'h0002_0000, 32'h0, 1'b0);
    set_op(1, 32'h0001_0000, 32'h0002_0000); expect_txn(1, 32'h0000_8000, 32'h0, 1'b0);
    set_op(2, 32'h0003_0000, 32'h0001_0000); expect_txn(2, 32'h0003_0000, 32'h0, 1'b0);
    set_op(3, 32'h0001_0000, 32'h0003_0000); expect_txn(3, 32'h0000_5555, 32'h0001_0000, 1'b0);
    bus.req = 4'b1111;
    serve_acks(4);
    wait_idle();

    // Pointer at 3: 4'b1001 serves 0 then 3
    set_op(0, 32'h0009_0000, 32'h0003_0000); expect_txn(0, 32'h0003_0000, 32'h0, 1'b0);
    set_op(3, 32'h0002_0000, 32'h0008_0000); expect_txn(3, 32'h0000_4000, 32'h0, 1'b0);
    bus.req = 4'b1001;
    serve_acks(2);
    wait_idle();

    // Single request on 2, operands visible on the grant edge
    set_op(2, 32'h0006_0000, 32'h0002_0000); expect_txn(2, 32'h0003_0000, 32'h0, 1'b0);
    bus.req = 4'b0100;
    serve_acks(1);
    check("grant_div_go", 64'(bus.div_go), 64'd1);
    check("grant_div_left", 64'(bus.div_left), 64'h0006_0000);
    check("grant_div_right", 64'(bus.div_right), 64'h0002_0000);
    check("grant_busy", 64'(bus.busy), 64'd1);
    wait_idle();

    // Consumer stall with req[1] pending
    bus.resp_ready = 1'b0;
    set_op(0, 32'h0009_0000, 32'h0003_0000); expect_txn(0, 32'h0003_0000, 32'h0, 1'b0);
    set_op(1, 32'h0001_0000, 32'h0002_0000); expect_txn(1, 32'h0000_8000, 32'h0, 1'b0);
    bus.req = 4'b0001;
    serve_acks(1);
    bus.req[1] = 1'b1;
    wait_valid();
    for (int c = 0; c < 10; c++) begin
      step(1);
      check("stall_valid", 64'(bus.resp_valid), 64'd1);
      check("stall_quotient", 64'(bus.resp_quotient), 64'h0003_0000);
      check("stall_id", 64'(bus.resp_id), 64'd0);
      check("stall_div_go", 64'(bus.div_go), 64'd0);
      check("stall_ack", 64'(bus.ack), 64'd0);
    end
    bus.resp_ready = 1'b1;
    serve_acks(1);
    wait_idle();

    // Stray div_done in IDLE
    inj_done = 1'b1;
    step(1);
    inj_done = 1'b0;
    check("idle_done_busy", 64'(bus.busy), 64'd0);
    check("idle_done_valid", 64'(bus.resp_valid), 64'd0);
    check("idle_done_go", 64'(bus.div_go), 64'd0);
    check("idle_done_quot", 64'(bus.resp_quotient), 64'h0000_8000);

    // Stray div_done in RESP
    bus.resp_ready = 1'b0;
    set_op(3, 32'h0002_0000, 32'h0008_0000); expect_txn(3, 32'h0000_4000, 32'h0, 1'b0);
    bus.req = 4'b1000;
    serve_acks(1);
    wait_valid();
    inj_done = 1'b1;
    step(1);
    inj_done = 1'b0;
    step(1);
    check("resp_done_quot", 64'(bus.resp_quotient), 64'h0000_4000);
    check("resp_done_rem", 64'(bus.resp_remainder), 64'd0);
    check("resp_done_valid", 64'(bus.resp_valid), 64'd1);
    check("resp_done_busy", 64'(bus.busy), 64'd1);
    bus.resp_ready = 1'b1;
    wait_idle();

    // Divide by zero on requester 1
    set_op(1, 32'h0005_0000, 32'h0000_0000);
`ifdef STD_FP_DIV_ARB_DIVZERO_EN
    expect_txn(1, 32'hFFFF_FFFF, 32'h0005_0000, 1'b1);
`else
    expect_txn(1, 32'hFFFF_FFFF, 32'h0005_0000, 1'b0);
`endif
    bus.req = 4'b0010;
    serve_acks(1);
    go_seen = bus.div_go;
    for (int c = 0; c < 100 && bus.busy; c++) begin
      step(1);
      go_seen = go_seen | bus.div_go;
    end
`ifdef STD_FP_DIV_ARB_DIVZERO_EN
    check("divzero_go", 64'(go_seen), 64'd0);
`else
    check("divzero_go", 64'(go_seen), 64'd1);
`endif
    wait_idle();

    // Reset while the divider is running
    set_op(2, 32'h0003_0000, 32'h0001_0000);
    ack_q.push_back(2);
    bus.req = 4'b0100;
    serve_acks(1);
    step(2);
    check("midop_go_before", 64'(bus.div_go), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midop_go", 64'(bus.div_go), 64'd0);
    check("midop_busy", 64'(bus.busy), 64'd0);
    check("midop_left", 64'(bus.div_left), 64'd0);
    check("midop_id", 64'(bus.resp_id), 64'd0);
    check("midop_valid", 64'(bus.resp_valid), 64'd0);
    bus.req = '0;
    step(2);
    reset_n = 1'b1;
    step(1);
    set_op(1, 32'h0001_0000, 32'h0002_0000); expect_txn(1, 32'h0000_8000, 32'h0, 1'b0);
    set_op(3, 32'h0001_0000, 32'h0003_0000); expect_txn(3, 32'h0000_5555, 32'h0001_0000, 1'b0);
    bus.req = 4'b1010;
    serve_acks(2);
    wait_idle();

    step(3);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("ack_drained", 64'(ack_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
